vga_rgb_reducer: RTL and testbench

VGA_RGB_REDUCER -- requirements
Module: vga_rgb_reducer

---
 rtl/vga_rgb_reducer.sv | 153 +++++++++++++++
 tb/tb_vga_rgb_reducer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rgb_reducer.sv
// vga_rgb_reducer: two-stage colour depth reducer for a VGA pixel stream (truncate, round, ordered dither).
// Ordered dither modes 2/3 and their x/y/frame counters exist only when VGA_RGB_REDUCER_DITHER_EN is defined.
module vga_rgb_reducer #(
  parameter int IN_BITS         = 6,
  parameter int OUT_BITS        = 3,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_vga,
  input  logic                reset,
  input  logic [IN_BITS-1:0]  in_r,
  input  logic [IN_BITS-1:0]  in_g,
  input  logic [IN_BITS-1:0]  in_b,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic                in_de,
  input  logic [1:0]          mode,
  output logic [OUT_BITS-1:0] out_r,
  output logic [OUT_BITS-1:0] out_g,
  output logic [OUT_BITS-1:0] out_b,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_de
);

  localparam int D  = IN_BITS - OUT_BITS;
  localparam int SW = IN_BITS + 1;
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [SW-1:0] HALF    = SW'((32'd1 << D) >> 1);
  localparam logic [SW-1:0] MAX_VAL = SW'((32'd1 << IN_BITS) - 32'd1);

  logic [IN_BITS-1:0] s1_r, s1_g, s1_b;
  logic               s1_hsync, s1_vsync, s1_de;
  logic [1:0]         s1_mode;
  logic [SW-1:0]      s1_t;
  logic [SW-1:0]      t_val;
  logic [SW-1:0]      add;

  // Add, clamp to full scale, then keep the top OUT_BITS; with D=0 the add is always zero.
  function automatic logic [OUT_BITS-1:0] reduce_ch(input logic [IN_BITS-1:0] c,
                                                     input logic [SW-1:0] a);
    logic [SW-1:0] sum;
    sum = {1'b0, c} + a;
    if (sum > MAX_VAL) sum = MAX_VAL;
    return OUT_BITS'(sum >> D);
  endfunction

`ifdef VGA_RGB_REDUCER_DITHER_EN
  localparam int T_SHR = (D <= 4) ? (4 - D) : 0;
  localparam int T_SHL = (D > 4)  ? (D - 4) : 0;

  logic       hs_prev, vs_prev;
  logic [1:0] x_cnt, y_cnt;
  logic       frame;
  logic       hs_edge, vs_edge;
  logic [1:0] x_eff, y_eff, x_idx;
  logic       frame_eff;

  function automatic logic [SW-1:0] bayer_threshold(input logic [1:0] x, input logic [1:0] y);
    logic [3:0]  b;
    int unsigned tv;
    case ({y, x})
      4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
      4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
      4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
      4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
    endcase
    tv = (32'(b) >> T_SHR) << T_SHL;
    return SW'(tv);
  endfunction

  // Counter values seen by the pixel sampled this cycle: edges take effect immediately, vsync clear wins.
  always_comb begin
    hs_edge   = (in_hsync != SYNC_IDLE) && (hs_prev == SYNC_IDLE);
    vs_edge   = (in_vsync != SYNC_IDLE) && (vs_prev == SYNC_IDLE);
    x_eff     = hs_edge ? 2'd0 : x_cnt;
    y_eff     = y_cnt;
    if (vs_edge)      y_eff = 2'd0;
    else if (hs_edge) y_eff = y_cnt + 2'd1;
    frame_eff = frame ^ vs_edge;
    x_idx     = (mode == 2'd3) ? (x_eff ^ {frame_eff, frame_eff}) : x_eff;
    t_val     = bayer_threshold(x_idx, y_eff);
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      hs_prev <= SYNC_IDLE;
      vs_prev <= SYNC_IDLE;
      x_cnt   <= 2'd0;
      y_cnt   <= 2'd0;
      frame   <= 1'b0;
    end else begin
      hs_prev <= in_hsync;
      vs_prev <= in_vsync;
      x_cnt   <= x_eff + {1'b0, in_de};
      y_cnt   <= y_eff;
      frame   <= frame_eff;
    end
  end
`else
  always_comb t_val = '0;
`endif

  // Stage 1: capture the pixel together with its mode and threshold so a mode change never splits a pixel.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_hsync <= SYNC_IDLE;
      s1_vsync <= SYNC_IDLE;
      s1_de    <= 1'b0;
      s1_mode  <= 2'd0;
      s1_t     <= '0;
    end else begin
      s1_r     <= in_r;
      s1_g     <= in_g;
      s1_b     <= in_b;
      s1_hsync <= in_hsync;
      s1_vsync <= in_vsync;
      s1_de    <= in_de;
      s1_mode  <= mode;
      s1_t     <= t_val;
    end
  end

  // Without the dither build, modes 2 and 3 fall back to rounding.
  always_comb begin
    add = HALF;
    if (s1_mode == 2'd0) add = '0;
`ifdef VGA_RGB_REDUCER_DITHER_EN
    else if (s1_mode[1]) add = s1_t;
`endif
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_hsync <= SYNC_IDLE;
      out_vsync <= SYNC_IDLE;
      out_de    <= 1'b0;
    end else begin
      out_r     <= s1_de ? reduce_ch(s1_r, add) : '0;
      out_g     <= s1_de ? reduce_ch(s1_g, add) : '0;
      out_b     <= s1_de ? reduce_ch(s1_b, add) : '0;
      out_hsync <= s1_hsync;
      out_vsync <= s1_vsync;
      out_de    <= s1_de;
    end
  end

endmodule

// File: tb/tb_vga_rgb_reducer.sv
// tb_vga_rgb_reducer: directed literal checks plus randomized stimulus against a frame-position model.
module tb_vga_rgb_reducer;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 3;
  localparam int D        = IN_BITS - OUT_BITS;
  localparam int HALF     = (1 << D) / 2;
  localparam int MAXV     = (1 << IN_BITS) - 1;
  localparam int SHR      = (D <= 4) ? (4 - D) : 0;
  localparam int SHL      = (D > 4) ? (D - 4) : 0;
`ifdef VGA_RGB_REDUCER_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  typedef struct packed {
    logic [OUT_BITS-1:0] r;
    logic [OUT_BITS-1:0] g;
    logic [OUT_BITS-1:0] b;
    logic                hs;
    logic                vs;
    logic                de;
  } out_t;

  localparam out_t RST = '{r: '0, g: '0, b: '0, hs: 1'b1, vs: 1'b1, de: 1'b0};

  logic                clk_vga = 1'b0;
  logic                reset;
  logic [IN_BITS-1:0]  in_r, in_g, in_b;
  logic                in_hsync, in_vsync, in_de;
  logic [1:0]          mode;
  logic [OUT_BITS-1:0] out_r, out_g, out_b;
  logic                out_hsync, out_vsync, out_de;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  out_t exp_out;
  out_t pend;
  int   line_out [4];

  int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int m_x, m_y, m_f;
  bit m_hs_prev, m_vs_prev;

  vga_rgb_reducer #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk_vga(clk_vga), .reset(reset),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .mode(mode),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic int reduce_ch(int c, int m, int t);
    int s;
    if (m == 0) return c >> D;
    s = c + ((m == 1 || !DITHER) ? HALF : t);
    if (s > MAXV) s = MAXV;
    return s >> D;
  endfunction

  // Drives one input cycle; the model predicts what the outputs show after the coming clock edge.
  task automatic applyStimulus(input int r, input int g, input int b,
                               input bit de, input bit hs, input bit vs, input int m);
    bit hs_a, vs_a;
    int xi, t;
    in_r = IN_BITS'(r); in_g = IN_BITS'(g); in_b = IN_BITS'(b);
    in_de = de; in_hsync = hs; in_vsync = vs; mode = 2'(m);
    exp_out = reset ? RST : pend;
    if (reset) begin
      pend = RST;
      m_x = 0; m_y = 0; m_f = 0; m_hs_prev = 0; m_vs_prev = 0;
    end else begin
      hs_a = !hs;
      vs_a = !vs;
      if (vs_a && !m_vs_prev) begin
        m_f = 1 - m_f;
        m_y = 0;
      end else if (hs_a && !m_hs_prev) begin
        m_y = (m_y + 1) % 4;
      end
      if (hs_a && !m_hs_prev) m_x = 0;
      xi = (m == 3 && m_f == 1) ? (3 - m_x) : m_x;
      t = bayer[m_y][xi] * (1 << SHL) / (1 << SHR);
      pend.de = de; pend.hs = hs; pend.vs = vs;
      pend.r = de ? OUT_BITS'(reduce_ch(r, m, t)) : '0;
      pend.g = de ? OUT_BITS'(reduce_ch(g, m, t)) : '0;
      pend.b = de ? OUT_BITS'(reduce_ch(b, m, t)) : '0;
      if (de) m_x = (m_x + 1) % 4;
      m_hs_prev = hs_a;
      m_vs_prev = vs_a;
    end
    @(negedge clk_vga);
  endtask

  task automatic checkOutput(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic idle(input int m);
    applyStimulus(0, 0, 0, 0, 1, 1, m);
  endtask

  task automatic runLine(input int m, input int val);
    applyStimulus(0, 0, 0, 0, 0, 0, m);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(val, val, val, 1, 1, 1, m);
      if (i > 0) line_out[i-1] = int'(out_r);
    end
    idle(m);
    line_out[3] = int'(out_r);
  endtask

  // Every cycle, the DUT outputs must equal the model's prediction for that edge.
  always @(posedge clk_vga) begin
    #2;
    if (chk_en) begin
      n_cmp++;
      if ({out_r, out_g, out_b, out_hsync, out_vsync, out_de} != exp_out) begin
        n_fail++;
        $display("[TB] FAIL model_cmp @%0t: got r%0d g%0d b%0d hs%0b vs%0b de%0b, expected r%0d g%0d b%0d hs%0b vs%0b de%0b",
                 $time, out_r, out_g, out_b, out_hsync, out_vsync, out_de,
                 exp_out.r, exp_out.g, exp_out.b, exp_out.hs, exp_out.vs, exp_out.de);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, g, b, m;
    bit hs, vs;

    reset = 1'b1;
    applyStimulus(63, 63, 63, 1, 0, 0, 1);
    chk_en = 1'b1;
    applyStimulus(63, 63, 63, 1, 0, 0, 1);
    checkOutput("reset_r", int'(out_r), 0);
    checkOutput("reset_de", int'(out_de), 0);
    checkOutput("reset_hsync", int'(out_hsync), 1);
    checkOutput("reset_vsync", int'(out_vsync), 1);
    reset = 1'b0;
    idle(0);
    idle(0);

    applyStimulus(20, 63, 0, 1, 1, 1, 0);
    checkOutput("mode0_not_early_de", int'(out_de), 0);
    idle(0);
    checkOutput("mode0_r20", int'(out_r), 2);
    checkOutput("mode0_g63", int'(out_g), 7);
    checkOutput("mode0_b0", int'(out_b), 0);
    checkOutput("mode0_de", int'(out_de), 1);

    applyStimulus(20, 63, 28, 1, 1, 1, 1);
    idle(1);
    checkOutput("mode1_r20", int'(out_r), 3);
    checkOutput("mode1_g63_clamp", int'(out_g), 7);
    checkOutput("mode1_b28", int'(out_b), 4);

    idle(1);
    applyStimulus(63, 63, 63, 0, 0, 0, 1);
    checkOutput("sync_not_early", int'(out_hsync), 1);
    idle(1);
    checkOutput("blank_r", int'(out_r), 0);
    checkOutput("blank_de", int'(out_de), 0);
    checkOutput("hsync_delayed", int'(out_hsync), 0);
    checkOutput("vsync_delayed", int'(out_vsync), 0);
    idle(1);
    checkOutput("hsync_release", int'(out_hsync), 1);

    applyStimulus(20, 20, 20, 1, 1, 1, 2);
    applyStimulus(20, 20, 20, 1, 1, 1, 2);
    reset = 1'b1;
    applyStimulus(20, 20, 20, 1, 1, 1, 2);
    checkOutput("midreset_r", int'(out_r), 0);
    checkOutput("midreset_de", int'(out_de), 0);
    checkOutput("midreset_hsync", int'(out_hsync), 1);
    reset = 1'b0;
    applyStimulus(20, 20, 20, 1, 1, 1, 2);
    checkOutput("postreset_cleared_de", int'(out_de), 0);
    applyStimulus(20, 20, 20, 1, 1, 1, 2);
    checkOutput("postreset_px0", int'(out_r), DITHER ? 2 : 3);
    idle(2);
    checkOutput("postreset_px1", int'(out_r), 3);
    idle(2);

`ifdef VGA_RGB_REDUCER_DITHER_EN
    runLine(2, 20);
    checkOutput("dither_m2_x0", line_out[0], 2);
    checkOutput("dither_m2_x1", line_out[1], 3);
    checkOutput("dither_m2_x2", line_out[2], 2);
    checkOutput("dither_m2_x3", line_out[3], 3);
    runLine(3, 20);
    checkOutput("dither_m3_f0_x0", line_out[0], 2);
    checkOutput("dither_m3_f0_x1", line_out[1], 3);
    runLine(3, 20);
    checkOutput("dither_m3_f1_x0", line_out[0], 3);
    checkOutput("dither_m3_f1_x1", line_out[1], 2);
    checkOutput("dither_m3_f1_x2", line_out[2], 3);
    checkOutput("dither_m3_f1_x3", line_out[3], 2);
`else
    runLine(2, 20);
    checkOutput("nodither_m2_x0", line_out[0], 3);
    checkOutput("nodither_m2_x1", line_out[1], 3);
    checkOutput("nodither_m2_x3", line_out[3], 3);
    runLine(3, 20);
    checkOutput("nodither_m3_x2", line_out[2], 3);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      m = $urandom_range(0, 3);
      r = ($urandom_range(0, 3) == 0) ? 63 : $urandom_range(0, 63);
      g = $urandom_range(0, 63);
      b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 63);
      if ($urandom_range(0, 9) < 6) begin
        applyStimulus(r, g, b, 1, 1, 1, m);
      end else begin
        hs = 1'($urandom_range(0, 1));
        vs = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        applyStimulus(r, g, b, 0, hs, vs, m);
      end
    end
    reset = 1'b0;
    idle(0);
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
